// File: rtl/fifo_types.sv
// Shared types for the FIFO command driver: command opcodes, FSM states and
// the handshake condition helper.
package fifo_types;

  typedef enum logic [1:0] {
    DRV_RESET = 2'b00,
    DRV_DEQ   = 2'b01,
    DRV_ENQ   = 2'b10,
    DRV_BOTH  = 2'b11
  } drv_op_e;

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_RST_HOLD = 2'd1;
  localparam logic [1:0] S_WAIT     = 2'd2;
  localparam logic [1:0] S_RESP     = 2'd3;

  typedef enum logic [1:0] {
    DRV_ST_IDLE     = S_IDLE,
    DRV_ST_RST_HOLD = S_RST_HOLD,
    DRV_ST_WAIT     = S_WAIT,
    DRV_ST_RESP     = S_RESP
  } drv_state_e;

  function automatic logic op_has_enq(input drv_op_e op);
    return op[1];
  endfunction

  function automatic logic op_has_deq(input drv_op_e op);
    return op[0];
  endfunction

  // Bit 1 of the opcode requests an enqueue, bit 0 a dequeue; each needs its own FIFO flag.
  function automatic logic cond_met(input drv_op_e op, input logic ready, input logic valid);
    return (!op_has_enq(op) || ready) && (!op_has_deq(op) || valid);
  endfunction

endpackage

// File: rtl/fifo_cmd_timer.sv
// Loadable down-counter shared by the reset-hold and handshake-wait phases.
// done is high whenever the count has reached zero.
module fifo_cmd_timer #(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         done
);

  logic [W-1:0] r_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else if (load) begin
      r_count <= load_val;
    end else if (en && (r_count != '0)) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign done = (r_count == '0);

endmodule

// File: rtl/fifo_cmd_driver.sv
// Command-driven stimulus engine for the FIFO port: one command at a time,
// one timestamped response per command. Optional WAIT timeout: FIFO_CMD_DRIVER_TIMEOUT_EN.
module fifo_cmd_driver
  import fifo_types::*;
#(
  parameter int WIDTH      = 8,
  parameter int RST_CYCLES = 2,
  parameter int TIMEOUT    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_word,
  output logic             fifo_rst_n,
  output logic             valid_i,
  output logic [WIDTH-1:0] data_i,
  input  logic             ready_o,
  input  logic             valid_o,
  input  logic [WIDTH-1:0] data_o,
  output logic             yumi,
  output logic             rsp_valid,
  output logic [1:0]       rsp_op,
  output logic [WIDTH-1:0] rsp_word,
  output logic             rsp_err,
  output logic [31:0]      rsp_time
);

  localparam int TMAX = (RST_CYCLES > TIMEOUT) ? RST_CYCLES : TIMEOUT;
  localparam int TW   = $clog2(TMAX + 1);
  localparam logic [TW-1:0] RST_LOAD = TW'(RST_CYCLES - 1);

  logic [1:0]       r_state;
  drv_op_e          r_op;
  logic [WIDTH-1:0] r_word;
  logic [WIDTH-1:0] r_rsp_word;
  logic             r_rsp_err;
  logic [31:0]      r_rsp_time;
  logic [31:0]      r_cnt;

  logic w_accept;
  logic w_in_wait;
  logic w_cond;
  logic w_fire;
  logic w_expire;
  logic w_tdone;
  logic w_tload;
  logic w_ten;
  logic [TW-1:0] w_tload_val;

  assign w_accept  = (r_state == S_IDLE) && cmd_valid;
  assign w_in_wait = (r_state == S_WAIT);
  assign w_cond    = cond_met(r_op, ready_o, valid_o);
  // Strobes are qualified by rst so a reset landing mid-WAIT never leaks a handshake.
  assign w_fire    = w_in_wait && w_cond && !rst;

`ifdef FIFO_CMD_DRIVER_TIMEOUT_EN
  localparam logic [TW-1:0] TO_LOAD = TW'(TIMEOUT - 1);
  assign w_tload     = w_accept;
  assign w_tload_val = (cmd_op == DRV_RESET) ? RST_LOAD : TO_LOAD;
  assign w_ten       = (r_state == S_RST_HOLD) || w_in_wait;
  assign w_expire    = w_in_wait && !w_cond && w_tdone;
`else
  assign w_tload     = w_accept && (cmd_op == DRV_RESET);
  assign w_tload_val = RST_LOAD;
  assign w_ten       = (r_state == S_RST_HOLD);
  assign w_expire    = 1'b0;
`endif

  fifo_cmd_timer #(
    .W(TW)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (w_tload),
    .load_val (w_tload_val),
    .en       (w_ten),
    .done     (w_tdone)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_op       <= DRV_RESET;
      r_word     <= '0;
      r_rsp_word <= '0;
      r_rsp_err  <= 1'b0;
      r_rsp_time <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (cmd_valid) begin
            r_op    <= drv_op_e'(cmd_op);
            r_word  <= cmd_word;
            r_state <= (cmd_op == DRV_RESET) ? S_RST_HOLD : S_WAIT;
          end
        end
        S_RST_HOLD: begin
          if (w_tdone) begin
            r_state    <= S_RESP;
            r_rsp_word <= '0;
            r_rsp_err  <= 1'b0;
            // Timestamp the release cycle, i.e. the first cycle fifo_rst_n is high again.
            r_rsp_time <= r_cnt + 32'd1;
          end
        end
        S_WAIT: begin
          if (w_cond) begin
            r_state    <= S_RESP;
            r_rsp_word <= (r_op == DRV_ENQ) ? r_word : data_o;
            r_rsp_err  <= 1'b0;
            r_rsp_time <= r_cnt;
          end else if (w_expire) begin
            r_state    <= S_RESP;
            r_rsp_word <= '0;
            r_rsp_err  <= 1'b1;
            r_rsp_time <= r_cnt;
          end
        end
        S_RESP: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign cmd_ready  = !rst && (r_state == S_IDLE);
  assign fifo_rst_n = !(rst || (r_state == S_RST_HOLD));
  assign valid_i    = w_fire && op_has_enq(r_op);
  assign yumi       = w_fire && op_has_deq(r_op);
  assign data_i     = (!rst && w_in_wait) ? r_word : '0;
  assign rsp_valid  = !rst && (r_state == S_RESP);
  assign rsp_op     = rst ? 2'b00 : r_op;
  assign rsp_word   = rst ? '0 : r_rsp_word;
  assign rsp_err    = !rst && r_rsp_err;
  assign rsp_time   = rst ? 32'd0 : r_rsp_time;

endmodule
